// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_resp memory responder.
// Holds the bus width, the reset NOP instruction and the FSM/read-select encodings.
package mem_resp_pkg;

    localparam int          REG_BUS  = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_BUSY = 2'd1,
        MR_RESP = 2'd2
    } mr_state_e;

    // Source of mem_rdata: held value, fresh RAM word, or zero for out-of-range reads
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_ZERO = 2'd2
    } rdata_sel_e;

endpackage

// File: rtl/mem_resp_sp_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// one-cycle read. Contents are never reset.
module mem_resp_sp_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write and read-first registered read on the same enable
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Fixed-latency single-word memory responder: IDLE/BUSY/RESP FSM, request latches,
// range check and a held read-data output that resets to a NOP instruction.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [REG_BUS-1:0] mem_addr,
    input  logic [REG_BUS-1:0] mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic [REG_BUS-1:0] mem_rdata,
    output logic               mem_ready,
    output logic               mem_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam mr_state_e   ACCEPT_STATE = (LATENCY == 1) ? MR_RESP : MR_BUSY;

    mr_state_e   state_q, state_d;
    rdata_sel_e  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [29:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;

    logic [29:0]   acc_idx_s;
    logic          acc_we_s;
    logic          acc_in_range_s;
    logic          ram_en_s;
    logic [3:0]    ram_we_s;
    logic [31:0]   ram_rdata_s;
    logic          unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^mem_addr[1:0];

    // State, latches and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MR_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= 30'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= SEL_HOLD;
            hold_q  <= INST_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; requests outside IDLE are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            MR_IDLE: begin
                if (mem_req) begin
                    state_d = ACCEPT_STATE;
                end else begin
                    state_d = MR_IDLE;
                end
            end
            MR_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = MR_RESP;
                end else begin
                    state_d = MR_BUSY;
                end
            end
            MR_RESP: state_d = MR_IDLE;
            default: state_d = MR_IDLE;
        endcase
    end

    // Request latches and wait counter
    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (state_q == MR_IDLE && mem_req) begin
            cnt_d   = CNT_INIT;
            we_d    = mem_we;
            idx_d   = mem_addr[31:2];
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
        end else if (state_q == MR_BUSY) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // In IDLE the live request drives the RAM so LATENCY=1 reads can start at once
    always_comb begin
        if (state_q == MR_IDLE) begin
            acc_idx_s = mem_addr[31:2];
            acc_we_s  = mem_we;
        end else begin
            acc_idx_s = idx_q;
            acc_we_s  = we_q;
        end
        acc_in_range_s = (acc_idx_s < DEPTH_W);
        ram_we_s       = 4'd0;
        ram_en_s       = 1'b0;
        if (state_q == MR_RESP && we_q && acc_in_range_s) begin
            ram_we_s = wstrb_q;
            ram_en_s = 1'b1;
        end else if (state_d == MR_RESP && !acc_we_s && acc_in_range_s) begin
            ram_en_s = 1'b1;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    mem_resp_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (acc_idx_s[AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata_s)
    );

    // Response flags and read-data source, registered on the edge entering RESP
    always_comb begin
        ready_d = (state_d == MR_RESP);
        err_d   = (state_d == MR_RESP) && !acc_in_range_s;
        hold_d  = hold_q;
        sel_d   = SEL_HOLD;
        if (state_d == MR_RESP && !acc_we_s) begin
            sel_d = acc_in_range_s ? SEL_RAM : SEL_ZERO;
        end else begin
            sel_d = SEL_HOLD;
        end
        if (state_q == MR_RESP) begin
            hold_d = mem_rdata;
        end else begin
            hold_d = hold_q;
        end
    end

    // Read data is a RAM word only during a read RESP; otherwise the held value
    always_comb begin
        mem_rdata = hold_q;
        case (sel_q)
            SEL_RAM:  mem_rdata = ram_rdata_s;
            SEL_ZERO: mem_rdata = 32'd0;
            default:  mem_rdata = hold_q;
        endcase
    end

    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule
